axis_id_arbiter: RTL

//  Packet-level round-robin merge of NUM_PORTS AXI-S input streams onto one output stream.

---
 rtl/axis_id_arbiter_if.sv | 27 ++
 rtl/axis_id_arbiter.sv | 62 ++++++
 2 files changed

// File: rtl/axis_id_arbiter_if.sv
// axis_id_arbiter_if: bundled N-input / 1-output AXI-S signals for the ID arbiter
interface axis_id_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TID_WIDTH  = 2,
  parameter int NUM_PORTS  = 4
);
  localparam int KW = DATA_WIDTH / 8;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KW-1:0]         s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KW-1:0]                   m_axis_tkeep;
  logic                            m_axis_tlast;
  logic                            m_axis_tvalid;
  logic [TID_WIDTH-1:0]            m_axis_tid;
  logic                            m_axis_tready;
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );
endinterface

// File: rtl/axis_id_arbiter.sv
// axis_id_arbiter: packet-level round-robin merge of NUM_PORTS AXI-S streams tagged with source tid
module axis_id_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TID_WIDTH  = 2,
  parameter int NUM_PORTS  = 4
) (
  input logic clk,
  input logic reset,
  axis_id_arbiter_if.slave bus
);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, nxt;
  logic [TID_WIDTH-1:0] grant, pick;
  logic found, load, accept;
  // round-robin scan starting just after the last served port (grant doubles as last_grant)
  always_comb begin
    pick = grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++)
      if (!found && bus.s_axis_tvalid[(int'(grant) + k) % NUM_PORTS]) begin
        pick = TID_WIDTH'((int'(grant) + k) % NUM_PORTS);
        found = 1'b1;
      end
  end
  // state register and grant capture on arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= TID_WIDTH'(NUM_PORTS - 1);
    end else begin
      state <= nxt;
      if (state == IDLE && found) grant <= pick;
    end
  end
  // next state: arbitrate in IDLE, release the grant on the accepted tlast beat
  always_comb nxt = state == IDLE ? (found ? BUSY : IDLE) : (accept && bus.s_axis_tlast[grant] ? IDLE : BUSY);
  // per-port ready and input handshake
  always_comb begin
    load = state == BUSY && (!bus.m_axis_tvalid || bus.m_axis_tready);
    accept = load && bus.s_axis_tvalid[grant];
    bus.s_axis_tready = load ? NUM_PORTS'(1) << grant : '0;
  end
  // one-deep output register: load on accept, drop valid when drained with nothing new
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_axis_tdata <= '0;
      bus.m_axis_tkeep <= '0;
      bus.m_axis_tlast <= 1'b0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tid <= '0;
    end else if (accept) begin
      bus.m_axis_tdata <= bus.s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      bus.m_axis_tkeep <= bus.s_axis_tkeep[int'(grant)*KW +: KW];
      bus.m_axis_tlast <= bus.s_axis_tlast[grant];
      bus.m_axis_tvalid <= 1'b1;
      bus.m_axis_tid <= grant;
    end else if (bus.m_axis_tready) begin
      bus.m_axis_tvalid <= 1'b0;
    end
  end
endmodule
